loop_sequencer: RTL and testbench

- Controller stage directly upstream of the per-level wrap counters.
- Accepts one loop-nest instruction (inclusive max count per level) over a valid/ready handshake.
- Walks the nest innermost-first and emits one step per iteration, carrying the current index vector, over a valid/ready handshake to the datapath.
- Pulses done when the nest completes, then accepts the next instruction.

---
 rtl/loop_sequencer_pkg.sv | 28 ++
 rtl/loop_level_ctr.sv | 45 ++++
 rtl/loop_sequencer.sv | 131 +++++++++++++
 tb/tb_loop_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loop_sequencer_pkg
//  Description : Shared definitions for the loop-nest sequencer.
//                - seq_state_t : controller states (IDLE, RUN, FIN)
//                - vec_width() : packed index/max vector width helper
//  Revision    : 1.0 - initial release
// ============================================================================
package loop_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

  localparam int c_DEF_BIT_WIDTH  = 2;
  localparam int c_DEF_NUM_LEVELS = 3;

  // Width of a packed per-level vector (inst_max, step_idx).
  function automatic int vec_width(input int bit_width, input int num_levels);
    return bit_width * num_levels;
  endfunction

  localparam int c_DEF_VEC_W = c_DEF_BIT_WIDTH * c_DEF_NUM_LEVELS;

endpackage
`default_nettype wire

// File: rtl/loop_level_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : loop_level_ctr
//  Description : One level of the loop nest: a wrap counter with an
//                inclusive maximum.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                clear     - force counter to 0 (priority over inc)
//                inc       - advance counter (wraps to 0 when at max)
//                max_count - inclusive max for this level
//                out       - current index
//                at_max    - out == max_count
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_level_ctr #(
  parameter int BIT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc,
  input  logic [BIT_WIDTH-1:0] max_count,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 at_max
);

  logic [BIT_WIDTH-1:0] r_out;

  // The wrap is driven by the compare, so a max of 2^BIT_WIDTH-1 and any
  // smaller max behave identically rather than relying on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (clear) begin
      r_out <= '0;
    end else if (inc) begin
      r_out <= at_max ? '0 : r_out + BIT_WIDTH'(1);
    end
  end

  assign out    = r_out;
  assign at_max = (r_out == max_count);

endmodule
`default_nettype wire

// File: rtl/loop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : loop_sequencer
//  Description : Accepts one loop-nest instruction (inclusive max count per
//                level), walks the nest innermost-first emitting one step per
//                iteration, then pulses done and returns to idle.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                inst_valid - instruction offered
//                inst_ready - sequencer can accept an instruction
//                inst_max   - per-level inclusive max, level k at [k*BW +: BW]
//                step_valid - step_idx/step_last valid
//                step_ready - downstream consumes the step
//                step_idx   - current per-level index, same packing
//                step_last  - current step is the final iteration
//                busy       - instruction in progress
//                done       - one-cycle pulse after the last step is consumed
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int BIT_WIDTH  = 2,
  parameter int NUM_LEVELS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          inst_valid,
  output logic                                          inst_ready,
  input  logic [vec_width(BIT_WIDTH, NUM_LEVELS)-1:0]   inst_max,
  output logic                                          step_valid,
  input  logic                                          step_ready,
  output logic [vec_width(BIT_WIDTH, NUM_LEVELS)-1:0]   step_idx,
  output logic                                          step_last,
  output logic                                          busy,
  output logic                                          done
);

  localparam int c_VEC_W = vec_width(BIT_WIDTH, NUM_LEVELS);

  seq_state_t              r_state;
  seq_state_t              w_next_state;
  logic [c_VEC_W-1:0]      r_max;
  logic [NUM_LEVELS-1:0]   w_inc;
  logic [NUM_LEVELS-1:0]   w_at_max;
  logic                    w_accept;
  logic                    w_fire;
  logic                    w_last;

  assign w_accept = (r_state == IDLE) && inst_valid;
  assign w_fire   = (r_state == RUN) && step_ready;
  // Final iteration: every level sits at its latched max.
  assign w_last   = (r_state == RUN) && (&w_at_max);

  // Latched max is only loaded on accept, so input changes during RUN/FIN
  // cannot disturb the walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max <= '0;
    end else if (w_accept) begin
      r_max <= inst_max;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    inst_ready   = 1'b0;
    step_valid   = 1'b0;
    step_last    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        inst_ready = 1'b1;
        busy       = 1'b0;
        if (inst_valid) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        step_valid = 1'b1;
        step_last  = w_last;
        if (w_fire && w_last) begin
          w_next_state = FIN;
        end
      end
      FIN: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Ripple carry: level 0 advances on every non-final fire; a higher level
  // advances only when every level below it is wrapping.
  assign w_inc[0] = w_fire && !w_last;

  genvar k;
  generate
    for (k = 1; k < NUM_LEVELS; k++) begin : g_carry
      assign w_inc[k] = w_inc[k-1] && w_at_max[k-1];
    end

    for (k = 0; k < NUM_LEVELS; k++) begin : g_level
      loop_level_ctr #(
        .BIT_WIDTH (BIT_WIDTH)
      ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_accept),
        .inc       (w_inc[k]),
        .max_count (r_max[k*BIT_WIDTH +: BIT_WIDTH]),
        .out       (step_idx[k*BIT_WIDTH +: BIT_WIDTH]),
        .at_max    (w_at_max[k])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_loop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loop_sequencer
//  Description : Self-checking bench for loop_sequencer. Expected step order
//                is derived arithmetically: step n has level-k index
//                (n / prod_{j<k}(max_j+1)) mod (max_k+1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_loop_sequencer;

  localparam int BW = 2;
  localparam int NL = 3;
  localparam int VW = BW * NL;

  logic          clk;
  logic          rst;
  logic          inst_valid;
  logic          inst_ready;
  logic [VW-1:0] inst_max;
  logic          step_valid;
  logic          step_ready;
  logic [VW-1:0] step_idx;
  logic          step_last;
  logic          busy;
  logic          done;

  int n_cmp;
  int n_bad;

  loop_sequencer #(
    .BIT_WIDTH  (BW),
    .NUM_LEVELS (NL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_max   (inst_max),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_idx   (step_idx),
    .step_last  (step_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int total_steps(input logic [VW-1:0] m);
    int t;
    t = 1;
    for (int k = 0; k < NL; k++) t = t * (int'(m[k*BW +: BW]) + 1);
    return t;
  endfunction

  function automatic logic [VW-1:0] model_idx(input logic [VW-1:0] m, input int n);
    logic [VW-1:0] r;
    int rem;
    int d;
    r   = '0;
    rem = n;
    for (int k = 0; k < NL; k++) begin
      d = int'(m[k*BW +: BW]) + 1;
      r[k*BW +: BW] = BW'(rem % d);
      rem = rem / d;
    end
    return r;
  endfunction

  function automatic bit ready_pattern(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return ($urandom_range(0, 99) < 60);
  endfunction

  // Issue one instruction and follow it to completion, checking every cycle.
  // mode: 0 = always ready, 1 = ready 1,0,0 repeating, 2 = random ready.
  // scramble: keep inst_valid high with random inst_max during the walk.
  task automatic run_inst(input logic [VW-1:0] m, input int mode, input bit scramble,
                          input string tag);
    int total;
    int n;
    int cyc;
    bit fin;
    logic [VW-1:0] exp_idx;
    total = total_steps(m);
    @(negedge clk);
    n_cmp++;
    if ({inst_ready, step_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s idle_before_accept: got rdy/vld/busy=%b want 100", tag,
               {inst_ready, step_valid, busy});
    end
    inst_valid = 1'b1;
    inst_max   = m;
    step_ready = 1'b0;
    @(negedge clk);
    if (!scramble) inst_valid = 1'b0;
    n = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 4000) begin
      exp_idx = model_idx(m, n);
      n_cmp++;
      if ({step_valid, inst_ready, busy, done} !== 4'b1010) begin
        n_bad++;
        $display("FAIL %s run_flags step %0d: got vld/rdy/busy/done=%b want 1010", tag, n,
                 {step_valid, inst_ready, busy, done});
      end
      n_cmp++;
      if (step_idx !== exp_idx || step_last !== (n == total - 1)) begin
        n_bad++;
        $display("FAIL %s step %0d: got idx=%h last=%b want idx=%h last=%b", tag, n,
                 step_idx, step_last, exp_idx, (n == total - 1));
      end
      if (scramble) inst_max = VW'($urandom);
      step_ready = ready_pattern(mode, cyc);
      if (step_ready && step_valid) begin
        if (n == total - 1) fin = 1'b1;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    inst_valid = 1'b0;
    step_ready = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL %s timeout: consumed %0d steps want %0d", tag, n, total);
    end
    n_cmp++;
    if ({done, step_valid, inst_ready, busy} !== 4'b1001) begin
      n_bad++;
      $display("FAIL %s fin_cycle: got done/vld/rdy/busy=%b want 1001", tag,
               {done, step_valid, inst_ready, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, step_valid, inst_ready, busy} !== 4'b0010) begin
      n_bad++;
      $display("FAIL %s back_to_idle: got done/vld/rdy/busy=%b want 0010", tag,
               {done, step_valid, inst_ready, busy});
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst_max   = '0;
    step_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({inst_ready, step_valid, step_last, busy, done} !== 5'b10000 || step_idx !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy/vld/last/busy/done=%b idx=%h want 10000 idx=0",
               {inst_ready, step_valid, step_last, busy, done}, step_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_step();
    run_inst('0, 0, 1'b0, "all_zero");
  endtask

  task automatic test_basic();
    run_inst({2'd0, 2'd2, 2'd1}, 0, 1'b0, "basic_6");
  endtask

  task automatic test_stall();
    run_inst({2'd0, 2'd2, 2'd1}, 1, 1'b0, "stall_6");
  endtask

  task automatic test_full_wrap();
    run_inst({2'd3, 2'd3, 2'd3}, 0, 1'b1, "full_64");
  endtask

  task automatic test_reset_mid();
    int fires;
    int cyc;
    bit saw_bad;
    @(negedge clk);
    inst_valid = 1'b1;
    inst_max   = {2'd0, 2'd2, 2'd1};
    step_ready = 1'b0;
    @(negedge clk);
    inst_valid = 1'b0;
    step_ready = 1'b1;
    fires = 0;
    cyc = 0;
    while (fires < 3 && cyc < 50) begin
      if (step_valid) fires++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (step_idx !== model_idx({2'd0, 2'd2, 2'd1}, 3)) begin
      n_bad++;
      $display("FAIL reset_mid pre_abort: got idx=%h want %h", step_idx,
               model_idx({2'd0, 2'd2, 2'd1}, 3));
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({inst_ready, step_valid, step_last, busy, done} !== 5'b10000 || step_idx !== '0) begin
      n_bad++;
      $display("FAIL reset_mid async: got rdy/vld/last/busy/done=%b idx=%h want 10000 idx=0",
               {inst_ready, step_valid, step_last, busy, done}, step_idx);
    end
    step_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || step_valid || busy) saw_bad = 1'b1;
    end
    n_cmp++;
    if (saw_bad) begin
      n_bad++;
      $display("FAIL reset_mid after_abort: got done/vld/busy activity want none");
    end
    run_inst({2'd0, 2'd2, 2'd1}, 0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    logic [VW-1:0] m;
    for (int i = 0; i < 8; i++) begin
      m = VW'($urandom);
      run_inst(m, 2, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_inst({2'd1, 2'd0, 2'd3}, 0, 1'b0, "b2b_a");
    run_inst({2'd0, 2'd0, 2'd0}, 0, 1'b0, "b2b_b");
    run_inst({2'd2, 2'd1, 2'd0}, 2, 1'b0, "b2b_c");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_step();
    test_basic();
    test_stall();
    test_full_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
